mem_stage_mc: RTL and testbench

// - Parametrised MEM stage with MEM/WB pipeline register for the pipelined core.
// - Talks to a multi-cycle data memory over a req/ack handshake and stalls upstream while an access is outstanding.
// - Supports byte/half/word(/dword) loads and stores, sign/zero extension and misalignment detection.
// - Resolves the branch decision.

---
 rtl/mem_stage_mc.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mc.sv
// MEM stage with MEM/WB register; drives a multi-cycle req/ack data memory and stalls upstream meanwhile.
// Optional build macro MEM_TIMEOUT_EN adds a MAX_WAIT watchdog that reports bus_err on a missing ack.
//   state | meaning
//   IDLE  | no access outstanding; non-memory ops pass straight to the stage register
//   BUSY  | request on the bus, waiting for dmem_ack (or watchdog expiry)
//   DONE  | result held until downstream accepts with en
module mem_stage_mc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                en,
  input  logic                flush,
  input  logic                wb_en_i,
  input  logic                mem_rd_i,
  input  logic                mem_wr_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0]   pc_next_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic                is_branch_i,
  input  logic                zero_i,
  output logic                stall_o,
  output logic                branch_o,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_be,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                out_valid,
  output logic                wb_en,
  output logic                mem_to_reg,
  output logic [DATA_W-1:0]   read_data,
  output logic [ADDR_W-1:0]   alu_result,
  output logic [ADDR_W-1:0]   pc_next,
  output logic [REG_W-1:0]    rd,
  output logic                misalign,
  output logic                bus_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic              live, access, aligned, mem_op, mis, timeout, sbit;
  logic [OFF_W-1:0]  off;
  logic [BE_W-1:0]   lane_mask, req_be;
  logic [DATA_W-1:0] wdata_rep, req_wdata, hold_data, shifted, keep, load_data;
  logic [ADDR_W-1:0] req_addr, req_pc;
  logic [REG_W-1:0]  req_rd;
  logic [1:0]        req_size;
  logic              req_we, req_load, req_wb, req_uns, req_kill, hold_err;

  assign off    = addr_i[OFF_W-1:0];
  assign live   = in_valid & ~flush;
  assign access = live & (mem_rd_i | mem_wr_i);
  assign mem_op = access & aligned;
  assign mis    = access & ~aligned;

  always_comb begin
    aligned   = 1'b1;
    lane_mask = '1;
    wdata_rep = wdata_i;
    case (size_i)
      2'b00: begin
        lane_mask = BE_W'(1);
        wdata_rep = {BE_W{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned   = (off[0] == 1'b0);
        lane_mask = BE_W'(3);
        wdata_rep = {(BE_W/2){wdata_i[15:0]}};
      end
      2'b10: begin
        aligned   = (off[1:0] == 2'b00);
        lane_mask = BE_W'(15);
        wdata_rep = {(BE_W/4){wdata_i[31:0]}};
      end
      default: aligned = (DATA_W == 64) && (off == '0);
    endcase
  end

  // Load lane extraction uses the captured request, since upstream may flush during BUSY.
  assign shifted = dmem_rdata >> {req_addr[OFF_W-1:0], 3'b000};
  always_comb begin
    keep = '1;
    sbit = 1'b0;
    case (req_size)
      2'b00:   begin keep = DATA_W'(8'hFF);        sbit = shifted[7];  end
      2'b01:   begin keep = DATA_W'(16'hFFFF);     sbit = shifted[15]; end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: begin keep = '1;                    sbit = 1'b0;        end
    endcase
  end
  assign load_data = (shifted & keep) | ((~req_uns & sbit) ? ~keep : '0);

  assign dmem_req   = (state == BUSY);
  assign dmem_we    = req_we;
  assign dmem_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wdata = req_wdata;
  assign dmem_be    = req_be;
  assign branch_o   = is_branch_i & zero_i & live;
  assign stall_o    = reset & (((state == IDLE) & mem_op) | (state == BUSY) |
                               ((state == DONE) & ~en));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [CNT_W-1:0] cnt;
  assign timeout = (cnt == CNT_W'(MAX_WAIT - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (state != BUSY)  cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_addr   <= '0;  req_pc   <= '0;  req_wdata <= '0;  req_be  <= '0;
      req_rd     <= '0;  req_size <= '0;  req_we    <= 1'b0; req_load <= 1'b0;
      req_wb     <= 1'b0; req_uns <= 1'b0; req_kill <= 1'b0;
      hold_data  <= '0;  hold_err <= 1'b0;
      out_valid  <= 1'b0; wb_en <= 1'b0; mem_to_reg <= 1'b0; read_data <= '0;
      alu_result <= '0;  pc_next <= '0; rd <= '0; misalign <= 1'b0; bus_err <= 1'b0;
    end else begin
      if (flush && state != IDLE) req_kill <= 1'b1;
      // Any en cycle that does not deliver a result hands downstream a bubble.
      if (en && state != DONE && (state == BUSY || mem_op)) begin
        out_valid <= 1'b0;
        wb_en     <= 1'b0;
        misalign  <= 1'b0;
        bus_err   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (mem_op) begin
            state     <= BUSY;
            req_addr  <= addr_i;
            req_pc    <= pc_next_i;
            req_wdata <= wdata_rep;
            req_be    <= lane_mask << off;
            req_we    <= mem_wr_i;
            req_load  <= mem_rd_i;
            req_wb    <= wb_en_i;
            req_uns   <= unsigned_i;
            req_size  <= size_i;
            req_rd    <= rd_i;
            req_kill  <= 1'b0;
          end else if (en) begin
            out_valid  <= live;
            wb_en      <= wb_en_i & live & ~mis;
            mem_to_reg <= mem_rd_i;
            read_data  <= '0;
            alu_result <= addr_i;
            pc_next    <= pc_next_i;
            rd         <= rd_i;
            misalign   <= mis;
            bus_err    <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state     <= DONE;
            hold_data <= req_load ? load_data : '0;
            hold_err  <= 1'b0;
          end else if (timeout) begin
            state     <= DONE;
            hold_data <= '0;
            hold_err  <= 1'b1;
          end
        end
        DONE: begin
          if (en) begin
            state      <= IDLE;
            out_valid  <= ~(req_kill | flush);
            wb_en      <= req_wb & ~hold_err & ~(req_kill | flush);
            mem_to_reg <= req_load;
            read_data  <= hold_data;
            alu_result <= req_addr;
            pc_next    <= req_pc;
            rd         <= req_rd;
            misalign   <= 1'b0;
            bus_err    <= hold_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: constant vector table, directed multi-cycle sequences, and random ops
// checked against an arithmetic byte-lane model.
module tb_mem_stage_mc;
  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 0, en = 0, flush = 0, wb_en_i = 0, mem_rd_i = 0, mem_wr_i = 0;
  logic [1:0]  size_i = 0;
  logic        unsigned_i = 0, is_branch_i = 0, zero_i = 0, dmem_ack = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, pc_next_i = 0, dmem_rdata = 0;
  logic [4:0]  rd_i = 0;
  logic        stall_o, branch_o, dmem_req, dmem_we, out_valid, wb_en, mem_to_reg, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data, alu_result, pc_next;
  logic [3:0]  dmem_be;
  logic [4:0]  rd;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_stage_mc #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .en(en), .flush(flush),
    .wb_en_i(wb_en_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .pc_next_i(pc_next_i),
    .rd_i(rd_i), .is_branch_i(is_branch_i), .zero_i(zero_i), .stall_o(stall_o),
    .branch_o(branch_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .wb_en(wb_en), .mem_to_reg(mem_to_reg), .read_data(read_data),
    .alu_result(alu_result), .pc_next(pc_next), .rd(rd), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic valid, flush, wb, rd_op, wr_op, uns, br, zero;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata, pc;
    logic [4:0] rd;
    int dly;
    logic e_req, e_we, e_branch, e_ov, e_wb, e_mis, e_m2r;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic valid, logic fl, logic wb, logic rd_op, logic wr_op,
                              logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic [4:0] rdi, int dly, logic br, logic zero);
    vec_t v;
    v = '{default: '0};
    v.valid = valid; v.flush = fl; v.wb = wb; v.rd_op = rd_op; v.wr_op = wr_op;
    v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rd = rdi; v.dly = dly; v.br = br; v.zero = zero; v.pc = addr ^ 32'h1000_0000;
    v.e_m2r = rd_op;
    return v;
  endfunction

  function automatic vec_t ex(vec_t v, logic req, logic we, logic [3:0] be, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rdv, logic ov, logic wb, logic mis,
                              logic br);
    v.e_req = req; v.e_we = we; v.e_be = be; v.e_addr = a; v.e_wdata = wd;
    v.e_rdata = rdv; v.e_ov = ov; v.e_wb = wb; v.e_mis = mis; v.e_branch = br;
    return v;
  endfunction

  // Reference: byte-lane arithmetic over a little-endian 4-byte word.
  function automatic vec_t model(vec_t v);
    int nb, off;
    logic live, acc, al;
    logic [31:0] mask, val;
    nb   = 1 << v.size;
    off  = int'(v.addr % 4);
    live = v.valid && !v.flush;
    acc  = live && (v.rd_op || v.wr_op);
    al   = (v.size != 2'd3) && (v.addr % nb == 0);
    v.e_req = acc && al; v.e_we = v.wr_op; v.e_mis = acc && !al;
    v.e_addr = v.addr - 32'(off);
    v.e_be = '0; v.e_wdata = '0; v.e_rdata = '0;
    if (v.size != 2'd3)
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nb) v.e_be[b] = 1'b1;
        v.e_wdata[8*b +: 8] = v.wdata[8*(b % nb) +: 8];
      end
    if (v.e_req && v.rd_op) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      val  = (v.rdata >> (8*off)) & mask;
      if (!v.uns && val[8*nb-1]) val = val | ~mask;
      v.e_rdata = val;
    end
    v.e_ov = live; v.e_wb = v.wb && live && !v.e_mis;
    v.e_branch = v.br && v.zero && live; v.e_m2r = v.rd_op;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.valid; flush = v.flush; wb_en_i = v.wb; mem_rd_i = v.rd_op; mem_wr_i = v.wr_op;
    size_i = v.size; unsigned_i = v.uns; addr_i = v.addr; wdata_i = v.wdata; pc_next_i = v.pc;
    rd_i = v.rd; is_branch_i = v.br; zero_i = v.zero; en = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; mem_rd_i = 0; mem_wr_i = 0; is_branch_i = 0; wb_en_i = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string tag, input vec_t v);
    drive(v);
    #1;
    chk({tag, ".stall_issue"}, stall_o, v.e_req);
    chk({tag, ".branch"}, branch_o, v.e_branch);
    step();
    if (v.e_req) begin
      chk({tag, ".req"}, dmem_req, 1'b1);
      chk({tag, ".we"}, dmem_we, v.e_we);
      chk({tag, ".daddr"}, dmem_addr, v.e_addr);
      chk({tag, ".be"}, dmem_be, v.e_be);
      if (v.e_we) chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
      repeat (v.dly) step();
      chk({tag, ".req_held"}, dmem_req, 1'b1);
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      step();
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk({tag, ".req_done"}, dmem_req, 1'b0);
      en = 1'b0; #1;
      chk({tag, ".stall_done"}, stall_o, 1'b1);
      step();
      chk({tag, ".bubble"}, out_valid, 1'b0);
      en = 1'b1; #1;
      chk({tag, ".stall_en"}, stall_o, 1'b0);
      step();
    end else begin
      chk({tag, ".no_req"}, dmem_req, 1'b0);
    end
    idle_inputs();
    chk({tag, ".out_valid"}, out_valid, v.e_ov);
    chk({tag, ".wb_en"}, wb_en, v.e_wb);
    chk({tag, ".misalign"}, misalign, v.e_mis);
    chk({tag, ".bus_err"}, bus_err, 1'b0);
    if (v.e_ov) begin
      chk({tag, ".alu"}, alu_result, v.addr);
      chk({tag, ".rd"}, rd, v.rd);
      chk({tag, ".pc"}, pc_next, v.pc);
      chk({tag, ".m2r"}, mem_to_reg, v.e_m2r);
      chk({tag, ".rdata"}, read_data, v.e_rdata);
    end
  endtask

  vec_t tbl[14];
  vec_t rv;
  int n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // valid fl wb rd wr size uns addr wdata rdata rd dly br zero
    tbl[0]  = ex(mk(1,0,1,0,0,2'd2,0,32'h40,0,0,5,0,1,1), 0,0,4'h0,0,0,0, 1,1,0,1);
    tbl[1]  = ex(mk(1,0,1,1,0,2'd0,0,32'h103,0,32'h80AABBCC,3,2,0,0), 1,0,4'h8,32'h100,0,32'hFFFFFF80, 1,1,0,0);
    tbl[2]  = ex(mk(1,0,0,0,1,2'd1,0,32'h102,32'h1234,0,0,0,0,0), 1,1,4'hC,32'h100,32'h12341234,0, 1,0,0,0);
    tbl[3]  = ex(mk(1,0,1,1,0,2'd2,0,32'h2,0,0,6,0,0,0), 0,0,4'h0,0,0,0, 1,0,1,0);
    tbl[4]  = ex(mk(1,0,1,1,0,2'd1,1,32'h102,0,32'h80011234,7,0,0,0), 1,0,4'hC,32'h100,0,32'h00008001, 1,1,0,0);
    tbl[5]  = ex(mk(1,0,1,1,0,2'd1,0,32'h102,0,32'h80011234,8,1,0,0), 1,0,4'hC,32'h100,0,32'hFFFF8001, 1,1,0,0);
    tbl[6]  = ex(mk(1,0,1,1,0,2'd2,0,32'h204,0,32'hDEADBEEF,9,1,0,0), 1,0,4'hF,32'h204,0,32'hDEADBEEF, 1,1,0,0);
    tbl[7]  = ex(mk(1,0,0,0,1,2'd0,0,32'h301,32'hA5,0,0,0,0,0), 1,1,4'h2,32'h300,32'hA5A5A5A5,0, 1,0,0,0);
    tbl[8]  = ex(mk(1,0,1,1,0,2'd3,0,32'h8,0,0,10,0,0,0), 0,0,4'h0,0,0,0, 1,0,1,0);
    tbl[9]  = ex(mk(1,0,1,1,0,2'd0,1,32'h101,0,32'h0000F000,11,0,0,0), 1,0,4'h2,32'h100,0,32'h000000F0, 1,1,0,0);
    tbl[10] = ex(mk(1,1,1,1,0,2'd2,0,32'h10,0,0,12,0,1,1), 0,0,4'h0,0,0,0, 0,0,0,0);
    tbl[11] = ex(mk(0,0,1,0,0,2'd2,0,32'h50,0,0,13,0,1,1), 0,0,4'h0,0,0,0, 0,0,0,0);
    tbl[12] = ex(mk(1,0,1,0,1,2'd1,0,32'h101,32'h5555,0,14,0,0,0), 0,0,4'h0,0,0,0, 1,0,1,0);
    tbl[13] = ex(mk(1,0,0,0,1,2'd2,0,32'h8,32'hCAFEF00D,0,0,3,0,0), 1,1,4'hF,32'h8,32'hCAFEF00D,0, 1,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0); chk("rst.wb_en", wb_en, 0);
    chk("rst.read_data", read_data, 0); chk("rst.alu", alu_result, 0);
    chk("rst.rd", rd, 0); chk("rst.misalign", misalign, 0); chk("rst.bus_err", bus_err, 0);
    chk("rst.req", dmem_req, 0); chk("rst.stall", stall_o, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 14; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Stage register holds with en low; no mem op so no stall.
    do_op("hold_pre", tbl[0]);
    drive(mk(1,0,1,0,0,2'd2,0,32'h88,0,0,9,0,0,0));
    en = 1'b0; #1;
    chk("hold.stall", stall_o, 0);
    step();
    chk("hold.alu", alu_result, 32'h40); chk("hold.rd", rd, 5); chk("hold.ov", out_valid, 1);
    idle_inputs(); en = 1'b1; step();

    // Flush while BUSY: the access completes but the result is discarded.
    drive(mk(1,0,1,1,0,2'd2,0,32'h200,0,0,4,0,0,0));
    step();
    chk("flushb.req", dmem_req, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flushb.req_kept", dmem_req, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222; step(); dmem_ack = 1'b0;
    #1; chk("flushb.stall_en", stall_o, 0);
    step(); idle_inputs();
    chk("flushb.ov", out_valid, 0); chk("flushb.wb", wb_en, 0); chk("flushb.idle", dmem_req, 0);

    // Reset asserted mid-access drops everything on the spot.
    do_op("rstb_pre", tbl[0]);
    drive(mk(1,0,1,1,0,2'd2,0,32'h100,0,0,2,0,0,0));
    step();
    chk("rstb.req_before", dmem_req, 1);
    reset = 1'b0; #1;
    chk("rstb.req", dmem_req, 0); chk("rstb.stall", stall_o, 0);
    chk("rstb.ov", out_valid, 0); chk("rstb.alu", alu_result, 0); chk("rstb.rd", rd, 0);
    idle_inputs(); #1; reset = 1'b1;
    step();
    chk("rstb.idle_req", dmem_req, 0); chk("rstb.idle_stall", stall_o, 0);
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    chk("rstb.late_ack_req", dmem_req, 0); chk("rstb.late_ack_ov", out_valid, 0);

`ifdef MEM_TIMEOUT_EN
    drive(mk(1,0,1,1,0,2'd2,0,32'h400,0,0,6,0,0,0));
    step();
    n = 0;
    while (dmem_req && n < 20) begin n++; step(); end
    chk("tmo.busy_cycles", n, 4);
    step(); idle_inputs();
    chk("tmo.bus_err", bus_err, 1); chk("tmo.wb_en", wb_en, 0);
    chk("tmo.read_data", read_data, 0); chk("tmo.ov", out_valid, 1);
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    chk("tmo.late_ack", dmem_req, 0); chk("tmo.late_ov", out_valid, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      n = $urandom_range(0, 2);
      rv = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
              n == 1, n == 2, 2'($urandom_range(0, 3)), 1'($urandom),
              $urandom & 32'h0000_0FFF, $urandom, $urandom, 5'($urandom),
              $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      do_op($sformatf("rnd%0d", i), model(rv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
